// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave with byte lanes, configurable wait states and ERROR path.
// Define AHB_SRAM_RANGE_ERR_EN to reject addresses above the memory range.
module ahb_sram_slave #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 16,
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              HSEL,
  input  logic [ADDR_W-1:0] HADDR,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic [2:0]        HSIZE,
  input  logic [2:0]        HBURST,
  input  logic [3:0]        HPROT,
  input  logic [DATA_W-1:0] HWDATA,
  input  logic              HREADY,
  output logic [DATA_W-1:0] HRDATA,
  output logic              HREADYOUT,
  output logic              HRESP
);

  localparam int BW = DATA_W / 8;
  localparam int LW = $clog2(BW);
  localparam int IW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ERR1,
    S_ERR2
  } state_t;

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            r_state;
  logic [3:0]        r_cnt;
  logic              r_hreadyout;
  logic              r_hresp;
  logic              r_dp_valid;
  logic              r_write;
  logic [IW-1:0]     r_idx;
  logic [BW-1:0]     r_be;
  logic [DATA_W-1:0] r_rdata;

  logic [IW-1:0]     w_idx;
  logic [LW-1:0]     w_lo;
  logic [BW-1:0]     w_be;
  logic              w_unalign;
  logic              w_size_err;
  logic              w_range_err;
  logic              w_err;
  logic              w_accept;
  logic              w_commit;
  logic [DATA_W-1:0] w_rd_word;
  logic              w_unused;

  assign w_idx = HADDR[LW+IW-1:LW];
  assign w_lo  = HADDR[LW-1:0];

  // A lane is enabled when it shares the address bits above the size.
  always_comb begin
    w_be = '0;
    for (int i = 0; i < BW; i++) begin
      w_be[i] = ((LW'(i) ^ w_lo) >> HSIZE) == '0;
    end
    w_unalign = |(w_lo & ((LW'(1) << HSIZE) - LW'(1)));
  end

  assign w_size_err = HSIZE > 3'(LW);

`ifdef AHB_SRAM_RANGE_ERR_EN
  assign w_range_err = |(HADDR & ~ADDR_W'(BW * DEPTH - 1));
`else
  assign w_range_err = 1'b0;
`endif

  assign w_err = w_size_err | w_unalign | w_range_err;

  assign w_accept = HSEL & HREADY & HTRANS[1] &
                    ((r_state == S_IDLE) | (r_state == S_ERR2));

  assign w_commit = (r_state == S_IDLE) & r_dp_valid & r_write;

  // Forward bytes of a write completing in the same cycle.
  always_comb begin
    w_rd_word = mem[w_idx];
    for (int b = 0; b < BW; b++) begin
      if (w_commit && (r_idx == w_idx) && r_be[b]) begin
        w_rd_word[8*b +: 8] = HWDATA[8*b +: 8];
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (w_commit) begin
      for (int b = 0; b < BW; b++) begin
        if (r_be[b]) begin
          mem[r_idx][8*b +: 8] <= HWDATA[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_hreadyout <= 1'b1;
      r_hresp     <= 1'b0;
      r_dp_valid  <= 1'b0;
      r_write     <= 1'b0;
      r_idx       <= '0;
      r_be        <= '0;
      r_rdata     <= '0;
    end else begin
      unique case (r_state)
        S_IDLE, S_ERR2: begin
          if (w_accept) begin
            r_idx   <= w_idx;
            r_be    <= w_be;
            r_write <= HWRITE;
            if (!HWRITE) begin
              r_rdata <= w_rd_word;
            end
            if (w_err) begin
              r_state     <= S_ERR1;
              r_hreadyout <= 1'b0;
              r_hresp     <= 1'b1;
              r_dp_valid  <= 1'b0;
            end else if (WAIT_STATES > 0) begin
              r_state     <= S_WAIT;
              r_cnt       <= 4'(WAIT_STATES);
              r_hreadyout <= 1'b0;
              r_hresp     <= 1'b0;
              r_dp_valid  <= 1'b1;
            end else begin
              r_state     <= S_IDLE;
              r_hreadyout <= 1'b1;
              r_hresp     <= 1'b0;
              r_dp_valid  <= 1'b1;
            end
          end else begin
            r_state     <= S_IDLE;
            r_hreadyout <= 1'b1;
            r_hresp     <= 1'b0;
            r_dp_valid  <= 1'b0;
          end
        end
        S_WAIT: begin
          if (r_cnt == 4'd1) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_hreadyout <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_ERR1: begin
          r_state     <= S_ERR2;
          r_hreadyout <= 1'b1;
          r_hresp     <= 1'b1;
        end
        default: begin
          r_state     <= S_IDLE;
          r_hreadyout <= 1'b1;
          r_hresp     <= 1'b0;
          r_dp_valid  <= 1'b0;
        end
      endcase
    end
  end

  assign HREADYOUT = r_hreadyout;
  assign HRESP     = r_hresp;
  assign HRDATA    = (r_state == S_IDLE && r_dp_valid && !r_write) ?
                     r_rdata : '0;

  assign w_unused = ^{HBURST, HPROT, HTRANS[0], HADDR};

endmodule
